local_predictor_param: RTL and testbench

//  Parametrised two-level local branch predictor for the pipelined core; the

---
 rtl/bp_pkg.sv | 20 ++
 rtl/saturated_adder.sv | 15 +
 rtl/local_predictor_param.sv | 106 ++++++++++
 tb/tb_local_predictor_param.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and the saturating-counter step used by the local branch predictor.
// Pure combinational helpers; no latency and no flow control.
package bp_pkg;

  typedef enum logic {HASH_XOR = 1'b0, HASH_HIST = 1'b1} hash_mode_e;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  localparam int MAX_CTR_W = 16;

  // width is the live counter width; bits above it are zero on input.
  function automatic logic [MAX_CTR_W-1:0] sat_next(input logic [MAX_CTR_W-1:0] val,
                                                    input logic taken,
                                                    input int width);
    logic [MAX_CTR_W-1:0] top;
    top = (MAX_CTR_W'(1) << width) - MAX_CTR_W'(1);
    if (taken) sat_next = (val >= top) ? top : val + MAX_CTR_W'(1);
    else       sat_next = (val == '0) ? '0 : val - MAX_CTR_W'(1);
  endfunction

endpackage

// File: rtl/saturated_adder.sv
// Saturating up/down step of one CPT counter: +1 on taken, -1 otherwise, clamped.
// Combinational, zero latency; no backpressure.
module saturated_adder
  import bp_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] val,
  input  logic             taken,
  output logic [WIDTH-1:0] result
);

  assign result = WIDTH'(sat_next(MAX_CTR_W'(val), taken, WIDTH));

endmodule

// File: rtl/local_predictor_param.sv
// Two-level local branch predictor: combinational fetch read, one update per cycle from EX.
// Updates take effect at the next edge; they are dropped while stalled, clearing or sweeping.
module local_predictor_param
  import bp_pkg::*;
#(
  parameter int PC_IDX_W  = 8,
  parameter int HIST_W    = 4,
  parameter int CPT_IDX_W = 4,
  parameter int CTR_W     = 2,
  parameter int HASH_MODE = 0,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  output logic                 ready,
  input  logic [PC_IDX_W-1:0]  rd_pc_idx,
  output logic                 predict_taken,
  output logic [CPT_IDX_W-1:0] pred_cpt_idx,
  input  logic                 upd_valid,
  input  logic                 stall,
  input  logic [PC_IDX_W-1:0]  upd_pc_idx,
  input  logic [CPT_IDX_W-1:0] upd_cpt_idx,
  input  logic                 upd_taken
);

  localparam int LHT_DEPTH = 1 << PC_IDX_W;
  localparam int CPT_DEPTH = 1 << CPT_IDX_W;
  localparam int PTR_W     = (PC_IDX_W > CPT_IDX_W) ? PC_IDX_W : CPT_IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

  state_e           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;

  logic [HIST_W-1:0] lht [LHT_DEPTH];
  logic [CTR_W-1:0]  cpt [CPT_DEPTH];

  logic                 lht_sweep, cpt_sweep, upd_fire;
  logic [HIST_W-1:0]    lht_old, hist_new, rd_hist;
  logic [CTR_W-1:0]     cpt_old, cpt_new;
  logic [CPT_IDX_W-1:0] hist_ext, rd_idx;
  logic                 rd_ctr_msb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // The sweep covers the larger table; its last pointer value is all-ones.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (clear) begin
      state_nxt = INIT;
      ptr_nxt   = '0;
    end else if (state == INIT) begin
      ptr_nxt = ptr + PTR_W'(1);
      if (ptr == '1) state_nxt = RUN;
    end
  end

  assign ready     = (state == RUN);
  assign lht_sweep = {1'b0, ptr} < (PTR_W + 1)'(LHT_DEPTH);
  assign cpt_sweep = {1'b0, ptr} < (PTR_W + 1)'(CPT_DEPTH);
  assign upd_fire  = upd_valid & ~stall & ready & ~clear;

  assign lht_old  = lht[upd_pc_idx];
  assign hist_new = HIST_W'({upd_taken, lht_old} >> 1);
  assign cpt_old  = cpt[upd_cpt_idx];

  saturated_adder #(.WIDTH(CTR_W)) u_sat (
    .val    (cpt_old),
    .taken  (upd_taken),
    .result (cpt_new)
  );

  // Tables carry no reset; the init sweep establishes their contents.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      if (lht_sweep) lht[ptr[PC_IDX_W-1:0]]  <= '0;
      if (cpt_sweep) cpt[ptr[CPT_IDX_W-1:0]] <= CTR_INIT;
    end else if (upd_fire) begin
      lht[upd_pc_idx]  <= hist_new;
      cpt[upd_cpt_idx] <= cpt_new;
    end
  end

  always_comb begin
    rd_hist = lht[rd_pc_idx];
    if (BYPASS != 0 && upd_fire && rd_pc_idx == upd_pc_idx) rd_hist = hist_new;
    hist_ext = CPT_IDX_W'(rd_hist);
    if (HASH_MODE == int'(HASH_HIST)) rd_idx = hist_ext;
    else                              rd_idx = hist_ext ^ rd_pc_idx[CPT_IDX_W-1:0];
    rd_ctr_msb = cpt[rd_idx][CTR_W-1];
    if (BYPASS != 0 && upd_fire && rd_idx == upd_cpt_idx) rd_ctr_msb = cpt_new[CTR_W-1];
  end

  assign predict_taken = ready & rd_ctr_msb;
  assign pred_cpt_idx  = ready ? rd_idx : '0;

endmodule

// File: tb/tb_local_predictor_param.sv
// Scoreboard bench: directed stimulus pushes expected read results, a negedge monitor compares.
// Two instances (forwarding on / off) share every input.
module tb_local_predictor_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       upd_valid = 1'b0;
  logic       stall = 1'b0;
  logic       upd_taken = 1'b0;
  logic [7:0] rd_pc_idx = 8'h00;
  logic [7:0] upd_pc_idx = 8'h00;
  logic [3:0] upd_cpt_idx = 4'h0;

  logic       ready, predict_taken;
  logic [3:0] pred_cpt_idx;
  logic       ready_nb, predict_taken_nb;
  logic [3:0] pred_cpt_idx_nb;

  always #5 clk = ~clk;

  local_predictor_param dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ready(ready),
    .rd_pc_idx(rd_pc_idx), .predict_taken(predict_taken), .pred_cpt_idx(pred_cpt_idx),
    .upd_valid(upd_valid), .stall(stall), .upd_pc_idx(upd_pc_idx),
    .upd_cpt_idx(upd_cpt_idx), .upd_taken(upd_taken)
  );

  local_predictor_param #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ready(ready_nb),
    .rd_pc_idx(rd_pc_idx), .predict_taken(predict_taken_nb), .pred_cpt_idx(pred_cpt_idx_nb),
    .upd_valid(upd_valid), .stall(stall), .upd_pc_idx(upd_pc_idx),
    .upd_cpt_idx(upd_cpt_idx), .upd_taken(upd_taken)
  );

  typedef struct {
    string      name;
    logic       rdy;
    logic       tk;
    logic [3:0] idx;
    logic       tk_nb;
    logic [3:0] idx_nb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (ready !== e.rdy || ready_nb !== e.rdy ||
          predict_taken !== e.tk || pred_cpt_idx !== e.idx ||
          predict_taken_nb !== e.tk_nb || pred_cpt_idx_nb !== e.idx_nb) begin
        errors++;
        $display("FAIL %s: got rdy=%b/%b tk=%b idx=%h tk_nb=%b idx_nb=%h, want rdy=%b tk=%b idx=%h tk_nb=%b idx_nb=%h",
                 e.name, ready, ready_nb, predict_taken, pred_cpt_idx, predict_taken_nb,
                 pred_cpt_idx_nb, e.rdy, e.tk, e.idx, e.tk_nb, e.idx_nb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic r, input logic [7:0] pc,
                     input logic t, input logic [3:0] i, input logic tn, input logic [3:0] inb);
    exp_t e;
    rd_pc_idx = pc;
    e.name = name; e.rdy = r; e.tk = t; e.idx = i; e.tk_nb = tn; e.idx_nb = inb;
    sb.push_back(e);
    tick();
  endtask

  task automatic upd(input logic [7:0] pc, input logic [3:0] idx, input logic taken);
    upd_valid = 1'b1; upd_pc_idx = pc; upd_cpt_idx = idx; upd_taken = taken;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 256; i++) chk(name, 1'b0, 8'h05, 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  logic t3_dir [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic t3_exp [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    chk("reset", 1'b0, 8'h33, 1'b0, 4'h0, 1'b0, 4'h0);
    reset_n = 1'b1;
    sweep("init_busy");
    chk("init_done", 1'b1, 8'h05, 1'b0, 4'h5, 1'b0, 4'h5);

    // pc 0x05 taken four times: history 0,8,C,E,F shifts in at the MSB
    chk("t2_rd0", 1'b1, 8'h05, 1'b0, 4'h5, 1'b0, 4'h5); upd(8'h05, 4'h5, 1'b1);
    chk("t2_rd1", 1'b1, 8'h05, 1'b0, 4'hD, 1'b0, 4'hD); upd(8'h05, 4'hD, 1'b1);
    chk("t2_rd2", 1'b1, 8'h05, 1'b0, 4'h9, 1'b0, 4'h9); upd(8'h05, 4'h9, 1'b1);
    chk("t2_rd3", 1'b1, 8'h05, 1'b0, 4'hB, 1'b0, 4'hB); upd(8'h05, 4'hB, 1'b1);
    chk("t2_final", 1'b1, 8'h05, 1'b0, 4'hA, 1'b0, 4'hA);
    chk("t2_ctr5",  1'b1, 8'h15, 1'b1, 4'h5, 1'b1, 4'h5);
    chk("t2_ctr13", 1'b1, 8'h1D, 1'b1, 4'hD, 1'b1, 4'hD);
    chk("t2_ctr9",  1'b1, 8'h19, 1'b1, 4'h9, 1'b1, 4'h9);
    chk("t2_ctr11", 1'b1, 8'h1B, 1'b1, 4'hB, 1'b1, 4'hB);
    chk("t2_ctr10", 1'b1, 8'h0A, 1'b0, 4'hA, 1'b0, 4'hA);

    // counter 3 walks 01->10->11->11->10->01->00->00
    for (int k = 0; k < 7; k++) begin
      upd(8'h40, 4'h3, t3_dir[k]);
      chk("t3_sat", 1'b1, 8'h03, t3_exp[k], 4'h3, t3_exp[k], 4'h3);
    end

    upd_valid = 1'b1; stall = 1'b1; upd_pc_idx = 8'h07; upd_cpt_idx = 4'h7; upd_taken = 1'b1;
    for (int k = 0; k < 5; k++) chk("t4_stall", 1'b1, 8'h07, 1'b0, 4'h7, 1'b0, 4'h7);
    stall = 1'b0;
    tick();
    upd_valid = 1'b0;
    chk("t4_hist", 1'b1, 8'h07, 1'b0, 4'hF, 1'b0, 4'hF);
    chk("t4_ctr",  1'b1, 8'h17, 1'b1, 4'h7, 1'b1, 4'h7);

    // history forward only: new hist 8 -> idx 9 (counter 10); old idx 1 (counter 01)
    upd_valid = 1'b1; upd_pc_idx = 8'h21; upd_cpt_idx = 4'h1; upd_taken = 1'b1;
    chk("t5_hist_fwd", 1'b1, 8'h21, 1'b1, 4'h9, 1'b0, 4'h1);
    upd_valid = 1'b0;
    chk("t5_after", 1'b1, 8'h21, 1'b1, 4'h9, 1'b1, 4'h9);
    // both forwards: new hist 4 -> idx 5 == upd idx, counter 10 -> 01
    upd_valid = 1'b1; upd_pc_idx = 8'h21; upd_cpt_idx = 4'h5; upd_taken = 1'b0;
    chk("t5_both_fwd", 1'b1, 8'h21, 1'b0, 4'h5, 1'b1, 4'h9);
    upd_valid = 1'b0;
    chk("t5_after2", 1'b1, 8'h21, 1'b0, 4'h5, 1'b0, 4'h5);

    upd_valid = 1'b1; upd_pc_idx = 8'h05; upd_cpt_idx = 4'hA; upd_taken = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; upd_valid = 1'b0;
    sweep("clr_busy");
    chk("clr_done",  1'b1, 8'h05, 1'b0, 4'h5, 1'b0, 4'h5);
    chk("clr_ctr13", 1'b1, 8'h1D, 1'b0, 4'hD, 1'b0, 4'hD);
    chk("clr_h21",   1'b1, 8'h21, 1'b0, 4'h1, 1'b0, 4'h1);
    chk("clr_ctr3",  1'b1, 8'h03, 1'b0, 4'h3, 1'b0, 4'h3);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (100) tick();
    reset_n = 1'b0;
    chk("rst_mid", 1'b0, 8'h05, 1'b0, 4'h0, 1'b0, 4'h0);
    reset_n = 1'b1;
    sweep("rst_busy");
    chk("rst_done", 1'b1, 8'h05, 1'b0, 4'h5, 1'b0, 4'h5);
    chk("rst_ctr9", 1'b1, 8'h19, 1'b0, 4'h9, 1'b0, 4'h9);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
